// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues imem reads with req/ack, and hands
// instructions to decode through an output slot backed by a one-entry skid.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, tgt_q, tgt_d;
   logic        imem_req_q, imem_req_d;
   logic        if_valid_q, if_valid_d, skid_valid_q, skid_valid_d;
   logic [31:0] if_instr_q, if_instr_d, if_pc_q, if_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;

   logic        slot_free;
   logic [31:0] redir_tgt, pc_inc;
   logic        unused_redirect_lsbs;

   assign slot_free            = !if_valid_q || !stall;
   assign redir_tgt            = {redirect_pc[31:2], 2'b00};
   assign pc_inc               = pc_q + 32'd4;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      tgt_d        = tgt_q;
      if_valid_d   = if_valid_q;
      if_instr_d   = if_instr_q;
      if_pc_d      = if_pc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      if (redirect_valid) begin
         // A pending request must complete at its original address before
         // the target can be issued, so FETCH without ack parks in DRAIN.
         if_valid_d   = 1'b0;
         skid_valid_d = 1'b0;
         tgt_d        = redir_tgt;
         if ((state_q == S_FETCH || state_q == S_DRAIN) && !imem_ack) begin
            state_d = S_DRAIN;
         end else begin
            pc_d    = redir_tgt;
            state_d = S_FETCH;
         end
      end else begin
         if (if_valid_q && !stall) if_valid_d = 1'b0;
         case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
               if (imem_ack) begin
                  pc_d = pc_inc;
                  if (slot_free) begin
                     if_valid_d = 1'b1;
                     if_instr_d = imem_rdata;
                     if_pc_d    = pc_q;
                  end else begin
                     skid_valid_d = 1'b1;
                     skid_instr_d = imem_rdata;
                     skid_pc_d    = pc_q;
                     state_d      = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (slot_free) begin
                  if_valid_d   = 1'b1;
                  if_instr_d   = skid_instr_q;
                  if_pc_d      = skid_pc_q;
                  skid_valid_d = 1'b0;
                  state_d      = S_FETCH;
               end
            end
            S_DRAIN: begin
               if (imem_ack) begin
                  pc_d    = tgt_q;
                  state_d = S_FETCH;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      imem_req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         tgt_q        <= RESET_PC;
         imem_req_q   <= 1'b0;
         if_valid_q   <= 1'b0;
         if_instr_q   <= 32'd0;
         if_pc_q      <= 32'd0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= 32'd0;
         skid_pc_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         tgt_q        <= tgt_d;
         imem_req_q   <= imem_req_d;
         if_valid_q   <= if_valid_d;
         if_instr_q   <= if_instr_d;
         if_pc_q      <= if_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;
   assign if_pc4    = if_pc_q + 32'd4;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: memory model with variable ack delay, and a
// scoreboard of correct-path fetches checked against what decode consumes.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] XMASK  = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        if_valid;
   logic [31:0] if_instr, if_pc, if_pc4;

   int          n_chk = 0;
   int          n_fail = 0;
   int          ack_delay = 0;
   int          wcnt = 0;
   bit          mem_en = 1'b1;
   logic [31:0] sbq[$];
   logic [31:0] exp_addr = RST_PC;
   logic [31:0] popped;
   bit          drain = 1'b0;

   pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_addr(input string tag, input logic [31:0] t, input int max);
      for (int i = 0; i < max; i++) begin
         if (imem_req && imem_addr == t) break;
         tick();
      end
      chk(tag, imem_addr, t);
   endtask

   // memory: acks a request after ack_delay waiting cycles
   always begin
      @(posedge clk);
      #2;
      if (imem_req && mem_en && wcnt >= ack_delay) begin
         imem_ack = 1'b1;
         wcnt     = 0;
      end else begin
         imem_ack = 1'b0;
         wcnt     = imem_req ? wcnt + 1 : 0;
      end
      imem_rdata = imem_addr ^ XMASK;
   end

   // scoreboard: compare what decode takes, then model the coming edge
   always @(negedge clk) begin
      if (if_valid && !stall) begin
         chk("sb_avail", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            popped = sbq.pop_front();
            chk("if_pc", if_pc, popped);
            chk("if_instr", if_instr, popped ^ XMASK);
            chk("if_pc4", if_pc4, popped + 32'd4);
         end
      end
      if (rst) begin
         sbq.delete();
         exp_addr = RST_PC;
         drain    = 1'b0;
      end else if (redirect_valid) begin
         sbq.delete();
         drain    = imem_req && !imem_ack;
         exp_addr = {redirect_pc[31:2], 2'b00};
      end else if (imem_req && imem_ack) begin
         if (drain) drain = 1'b0;
         else begin
            chk("fetch_addr", imem_addr, exp_addr);
            sbq.push_back(exp_addr);
            exp_addr = exp_addr + 32'd4;
         end
      end
   end

   initial begin
      repeat (2) tick();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_pc4", if_pc4, 32'd4);
      rst = 1'b0;
      tick();
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, RST_PC);
      tick();
      chk("stream_valid", 32'(if_valid), 32'd1);
      chk("stream_pc", if_pc, RST_PC);
      tick();
      stall = 1'b1;
      tick();
      chk("hold_req0", 32'(imem_req), 32'd0);
      chk("hold_pc", if_pc, 32'h3004);
      tick();
      chk("hold_req1", 32'(imem_req), 32'd0);
      tick();
      chk("hold_req2", 32'(imem_req), 32'd0);
      stall = 1'b0;
      tick();
      chk("resume_req", 32'(imem_req), 32'd1);
      chk("resume_addr", imem_addr, 32'h300C);
      tick();
      ack_delay = 3;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3043;
      tick();
      redirect_valid = 1'b0;
      chk("drain_req", 32'(imem_req), 32'd1);
      chk("drain_addr0", imem_addr, 32'h3010);
      chk("drain_valid0", 32'(if_valid), 32'd0);
      tick();
      chk("drain_addr1", imem_addr, 32'h3010);
      chk("drain_valid1", 32'(if_valid), 32'd0);
      tick();
      chk("redir_addr", imem_addr, 32'h3040);
      chk("redir_valid", 32'(if_valid), 32'd0);
      ack_delay = 0;
      tick();
      stall = 1'b1;
      tick();
      chk("skid_req", 32'(imem_req), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3080;
      tick();
      redirect_valid = 1'b0;
      chk("flush_valid", 32'(if_valid), 32'd0);
      chk("flush_req", 32'(imem_req), 32'd1);
      chk("flush_addr", imem_addr, 32'h3080);
      tick();
      chk("flush_dlv_valid", 32'(if_valid), 32'd1);
      chk("flush_dlv_pc", if_pc, 32'h3080);
      stall = 1'b0;
      tick();
      ack_delay      = 4;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3100;
      tick();
      redirect_pc = 32'h3200;
      tick();
      redirect_valid = 1'b0;
      chk("dbl_hold_addr", imem_addr, 32'h3088);
      wait_addr("dbl_target", 32'h3200, 10);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3300;
      tick();
      redirect_valid = 1'b0;
      rst = 1'b1;
      chk("mid_drain_req", 32'(imem_req), 32'd1);
      chk("mid_drain_addr", imem_addr, 32'h3200);
      tick();
      rst = 1'b0;
      chk("abort_req", 32'(imem_req), 32'd0);
      chk("abort_addr", imem_addr, RST_PC);
      chk("abort_valid", 32'(if_valid), 32'd0);
      ack_delay = 0;
      tick();
      chk("refetch_req", 32'(imem_req), 32'd1);
      chk("refetch_addr", imem_addr, RST_PC);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFA;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (if_valid && if_pc == 32'hFFFF_FFFC) break;
         tick();
      end
      chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", if_pc4, 32'd0);
      tick();
      chk("wrap_next_valid", 32'(if_valid), 32'd1);
      chk("wrap_next_pc", if_pc, 32'd0);
      for (int i = 0; i < 300; i++) begin
         stall          = ($urandom_range(0, 3) == 0);
         ack_delay      = $urandom_range(0, 2);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom;
         tick();
      end
      stall          = 1'b0;
      redirect_valid = 1'b0;
      mem_en         = 1'b0;
      repeat (4) tick();
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer for the pipelined MIPS core. It owns the PC register and issues instruction-memory reads with a request/acknowledge handshake. It delivers fetched instructions to decode through a one-slot output register plus a one-entry skid buffer. It accepts taken-branch/jump redirects, which carry the target computed by the next-PC logic, and discards any wrong-path fetches.

## Interface
- RESET_PC, default 32'h0000_3000: first fetch address after reset (text segment base).
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- redirect_valid  in  1  execute stage resolved a taken branch/jump/jr this cycle.
- redirect_pc  in  32  target from next-PC logic; bits [1:0] ignored (forced 00).
- stall  in  1  decode cannot take the output slot this cycle.
- imem_req  out  1  read request; high in FETCH and DRAIN states only.
- imem_addr  out  32  fetch address (= PC register); stable while imem_req high and no ack.
- imem_ack  in  1  read complete this cycle; imem_rdata valid same cycle.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  output slot holds a valid instruction.
- if_instr  out  32  instruction in output slot.
- if_pc  out  32  address of if_instr.
- if_pc4  out  32  if_pc + 4 (link value for jal/jalr).

## Operation
- Consume rule: decode takes the slot at an edge where if_valid=1 and stall=0. The slot can accept at an edge if if_valid=0 or stall=0.
- States: IDLE, FETCH, DRAIN, HOLD. Reset state is IDLE.
- IDLE: imem_req=0. Next edge goes to FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - ack and slot can accept: slot <= {rdata, pc}, if_valid<=1, pc<=pc+4, stay FETCH.
  - ack and slot cannot accept: skid <= {rdata, pc}, skid_valid<=1, pc<=pc+4, go to HOLD.
  - no ack and slot consumed: if_valid<=0.
- HOLD: imem_req=0. When the slot can accept: slot <= skid, if_valid<=1, skid_valid<=0, go to FETCH.
- DRAIN: imem_req=1 with the old address held; returned data is dropped. On ack: pc<=tgt, go to FETCH.
- Redirect has highest priority over stall and ack, in every state. Effects at the edge:
  - if_valid<=0, skid_valid<=0, tgt<={redirect_pc[31:2],2'b00}.
  - FETCH with no ack: go to DRAIN; pc is unchanged so imem_addr stays stable.
  - FETCH with ack: data dropped, pc<=target, stay FETCH.
  - HOLD or IDLE: pc<=target, go to FETCH.
  - DRAIN: tgt is overwritten by the newest target; with ack, pc<=newest target and go to FETCH.
- pc+4 wraps modulo 2^32. No exception on wrap.
- No instruction is ever lost, duplicated or reordered on the correct path.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, tgt=RESET_PC.
  - if_valid=0, skid_valid=0, if_instr=0, if_pc=0, if_pc4=4.
  - imem_req=0, imem_addr=RESET_PC.
- rst asserted in any state, including mid-DRAIN with a pending request, aborts everything. imem_req is 0 in the cycle after the reset edge. The memory must tolerate a request withdrawn by reset.
- First request: the second cycle after rst deasserts (one IDLE cycle, then FETCH).
- Latency: an ack at edge N makes if_valid=1 from cycle N+1 (slot free case).
- Throughput: 1 instruction/cycle with a zero-wait memory and stall=0.
- imem_req and imem_addr change only at edges. Once raised with an address, that address holds until an ack (DRAIN included).
- Redirect visibility: a redirect at edge N gives if_valid=0 in cycle N+1.
  - First target request: cycle N+1 if FETCH-with-ack, HOLD or IDLE.
  - Otherwise: the cycle after the DRAIN ack.

## Test plan
- Reset: hold rst for 2 cycles → imem_req=0, if_valid=0, imem_addr=0x3000. The cycle after IDLE: imem_req=1, addr 0x3000.
- Streaming: ack every cycle, stall=0, rdata=addr^0xFFFF0000 → if_pc 0x3000, 0x3004, 0x3008 on consecutive cycles, if_pc4 = if_pc+4.
- Backpressure: raise stall when ack of 0x3008 arrives and hold 3 cycles → skid used, imem_req=0 during HOLD. After release, decode sees 0x3004 then 0x3008 exactly once, then the request resumes at 0x300C.
- Redirect mid-request: ack delayed 3 cycles on 0x3010, redirect_pc=0x3043 at cycle 1 → DRAIN with imem_addr held at 0x3010, its data dropped, next request at 0x3040, if_valid=0 throughout.
- Redirect with full skid and stall=1 → slot and skid both cleared. The next delivered if_pc is the target and stall is ignored for the flush.
- Double redirect in DRAIN (0x3100 then 0x3200) → next fetch at 0x3200. Assert rst mid-DRAIN → imem_req=0 the following cycle, then refetch at 0x3000.
